shifter_share_arbiter: RTL and testbench
========================================

Name: shifter_share_arbiter

Overview:
- Shares one combinational 4-bit barrel shifter (fourbitbarrelshifter) between two independent requesters.
- Arbitrates requests and drives the shifter's data and select inputs from a registered operand.
- Captures the shifter output into a result register and returns it with the requester ID over a valid/ready response channel.
- Keeps per-requester served counters for debug and performance visibility.

Parameters:
- FIXED_PRIO, 0, 0 = round-robin between requesters; 1 = requester 0 always wins a simultaneous request.
- CNT_W, 8, width of each served counter; counters wrap modulo 2^CNT_W.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 transfer accepted this cycle.
- req0_data  input  4  requester 0 operand.
- req0_sel  input  2  requester 0 shift amount.
- req1_valid, req1_ready, req1_data, req1_sel  (same as req0, for requester 1).
- resp_valid  output  1  result available.
- resp_ready  input  1  consumer accepts result.
- resp_data  output  4  registered shifter result.
- resp_id  output  1  requester that owns resp_data.
- shf_in  output  4  to shifter in[3:0]; bit 3 drives the shifter's MSB input.
- shf_sel  output  2  to shifter sel.
- shf_out  input  4  from shifter out.
- busy  output  1  high in any state other than IDLE.
- served0_cnt  output  CNT_W  responses completed for requester 0.
- served1_cnt  output  CNT_W  responses completed for requester 1.

Behaviour:
- Reset (async, rst_n low): state=IDLE; all outputs 0, including shf_in, shf_sel, resp_*, counters and busy.
  - Round-robin pointer last=1, so requester 0 wins first.
  - An in-flight operation is dropped; no response is produced for it after reset.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant is combinational from the valids. Only one valid: that requester wins.
  - Both valid: FIXED_PRIO=1 grants req0; otherwise grant the requester != last.
  - reqX_ready = (state==IDLE) && grantX. The non-granted ready stays 0.
  - Transfer on valid && ready: latch data into op_data, sel into op_sel and the ID into op_id; update last=op_id; go to EXEC.
- EXEC (exactly 1 cycle):
  - shf_in=op_data, shf_sel=op_sel, both registered outputs, stable all cycle.
  - On the clock edge: resp_data<=shf_out, resp_id<=op_id, resp_valid<=1; go to RESP.
- RESP:
  - Hold resp_valid, resp_data and resp_id stable until resp_ready.
  - On resp_valid && resp_ready: resp_valid<=0, increment the served counter of resp_id (wraps, no saturation), go to IDLE.
- shf_in and shf_sel keep the last operand outside EXEC; they are only sampled in EXEC.
- Latency: request accepted at edge N gives resp_valid high after edge N+1. With resp_ready held high, the next acceptance is possible at edge N+3.
- Throughput: at most one operation in flight; no request is accepted in EXEC or RESP (both readys 0).
- Requesters hold valid, data and sel stable until ready; valid may drop while ready=0 without effect.
- A request arriving during EXEC or RESP waits. Round-robin fairness still applies when both are pending on return to IDLE.
- resp_ready asserted while resp_valid=0 is ignored.

Test Plan:
- Bench model: shifter = rotate-left by sel.
- Reset, single request: req0 data=0001 sel=01, resp_ready=1.
  - Expect req0_ready in the same cycle, then resp_valid 2 edges later with resp_data=0010, resp_id=0, served0_cnt=1.
- Simultaneous requests, FIXED_PRIO=0: both valid and held, req0 1010/sel 00, req1 0011/sel 11.
  - Expect responses 1010 (id 0) then 1001 (id 1); served counters 1/1.
  - Repeat both: order is again 0 then 1 (alternating pointer).
- Same simultaneous stimulus with FIXED_PRIO=1 and req0 reasserted immediately: req0 is served twice before req1 gets its grant.
- Backpressure: resp_ready=0 for 5 cycles after resp_valid.
  - Expect resp_data and resp_id stable, busy=1, both readys 0, no counter change.
  - Raise resp_ready: one handshake, then IDLE.
- Async reset mid-op: drop rst_n during EXEC.
  - Expect immediate resp_valid=0, counters 0, shf_in/shf_sel 0.
  - After release, req1 alone is accepted normally.
- Counter wrap, CNT_W=2: 5 back-to-back req1 operations leave served1_cnt=1.

Source files
------------

// File: rtl/shifter_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : shifter_share_arbiter
//  Function : Shares one external 4-bit combinational barrel shifter between
//             two requesters. A grant is issued in IDLE, the operand drives
//             the shifter for one EXEC cycle, and the captured result is
//             returned with its owner ID over a valid/ready response channel.
//             Per-requester served counters give debug visibility.
//  Revision : 1.0  initial release
// ============================================================================
module shifter_share_arbiter #(
  parameter int FIXED_PRIO = 0,  // 0: round-robin on a tie, 1: requester 0 wins a tie
  parameter int CNT_W      = 8   // served counter width, wraps modulo 2^CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  // requester 0
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_data,
  input  logic [1:0]       req0_sel,
  // requester 1
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_data,
  input  logic [1:0]       req1_sel,
  // response channel
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [3:0]       resp_data,
  output logic             resp_id,
  // shared shifter connection
  output logic [3:0]       shf_in,
  output logic [1:0]       shf_sel,
  input  logic [3:0]       shf_out,
  // status
  output logic             busy,
  output logic [CNT_W-1:0] served0_cnt,
  output logic [CNT_W-1:0] served1_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q,      state_d;
  logic             last_q,       last_d;
  logic [3:0]       op_data_q,    op_data_d;
  logic [1:0]       op_sel_q,     op_sel_d;
  logic             op_id_q,      op_id_d;
  logic             resp_valid_q, resp_valid_d;
  logic [3:0]       resp_data_q,  resp_data_d;
  logic             resp_id_q,    resp_id_d;
  logic [CNT_W-1:0] served0_q,    served0_d;
  logic [CNT_W-1:0] served1_q,    served1_d;

  logic             grant0;
  logic             grant1;

  // Tie-break between simultaneous valids: fixed priority or the requester that was not served last.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      if ((FIXED_PRIO != 0) || last_q) begin
        grant0 = 1'b1;
      end else begin
        grant1 = 1'b1;
      end
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid;
    end
  end

  // Readys are only offered while idle; a grant implies the matching valid.
  assign req0_ready = (state_q == IDLE) && grant0;
  assign req1_ready = (state_q == IDLE) && grant1;

  // Next-state and datapath: accept in IDLE, capture shifter in EXEC, hand over in RESP.
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    op_data_d    = op_data_q;
    op_sel_d     = op_sel_q;
    op_id_d      = op_id_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_id_d    = resp_id_q;
    served0_d    = served0_q;
    served1_d    = served1_q;

    unique case (state_q)
      IDLE: begin
        if (req0_ready) begin
          op_data_d = req0_data;
          op_sel_d  = req0_sel;
          op_id_d   = 1'b0;
          last_d    = 1'b0;
          state_d   = EXEC;
        end else if (req1_ready) begin
          op_data_d = req1_data;
          op_sel_d  = req1_sel;
          op_id_d   = 1'b1;
          last_d    = 1'b1;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        // The operand has been on the shifter for a full cycle; its output is settled here.
        resp_data_d  = shf_out;
        resp_id_d    = op_id_q;
        resp_valid_d = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          if (resp_id_q) begin
            served1_d = served1_q + CNT_ONE;
          end else begin
            served0_d = served0_q + CNT_ONE;
          end
          state_d = IDLE;
        end
      end
      default: begin
        state_d      = IDLE;
        resp_valid_d = 1'b0;
      end
    endcase
  end

  // All state and registered outputs; an asynchronous reset drops any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_q       <= 1'b1;
      op_data_q    <= 4'd0;
      op_sel_q     <= 2'd0;
      op_id_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 4'd0;
      resp_id_q    <= 1'b0;
      served0_q    <= '0;
      served1_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      op_data_q    <= op_data_d;
      op_sel_q     <= op_sel_d;
      op_id_q      <= op_id_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_id_q    <= resp_id_d;
      served0_q    <= served0_d;
      served1_q    <= served1_d;
    end
  end

  // The operand registers drive the shifter directly and simply hold outside EXEC.
  assign shf_in      = op_data_q;
  assign shf_sel     = op_sel_q;
  assign resp_valid  = resp_valid_q;
  assign resp_data   = resp_data_q;
  assign resp_id     = resp_id_q;
  assign busy        = (state_q != IDLE);
  assign served0_cnt = served0_q;
  assign served1_cnt = served1_q;

endmodule
`default_nettype wire

// File: tb/tb_shifter_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shifter_share_arbiter
//  Function : Bench for shifter_share_arbiter. Instance 0 is round-robin with
//             2-bit counters, instance 1 is fixed-priority with 8-bit counters.
//             The shifter is modelled as rotate-left by sel.
//  Revision : 1.0  initial release
// ============================================================================
module tb_shifter_share_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // stimulus, indexed [instance][requester]
  logic [1:0][1:0]       rq_valid = '0;
  logic [1:0][1:0][3:0]  rq_data  = '0;
  logic [1:0][1:0][1:0]  rq_sel   = '0;
  logic [1:0]            rsp_ready = '0;

  // DUT outputs, indexed [instance]
  logic [1:0][1:0] rq_ready;
  logic [1:0]      rsp_valid;
  logic [1:0][3:0] rsp_data;
  logic [1:0]      rsp_id;
  logic [1:0][3:0] shf_in;
  logic [1:0][1:0] shf_sel;
  logic [1:0]      busy;
  logic [3:0]      shf_out_a, shf_out_b;
  logic [1:0]      cnt0_a, cnt1_a;
  logic [7:0]      cnt0_b, cnt1_b;

  int total = 0;
  int bad   = 0;

  function automatic logic [3:0] rotl(input logic [3:0] d, input logic [1:0] s);
    logic [7:0] t;
    t = {d, d} << s;
    return t[7:4];
  endfunction

  assign shf_out_a = rotl(shf_in[0], shf_sel[0]);
  assign shf_out_b = rotl(shf_in[1], shf_sel[1]);

  shifter_share_arbiter #(.FIXED_PRIO(0), .CNT_W(2)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(rq_valid[0][0]), .req0_ready(rq_ready[0][0]), .req0_data(rq_data[0][0]), .req0_sel(rq_sel[0][0]),
    .req1_valid(rq_valid[0][1]), .req1_ready(rq_ready[0][1]), .req1_data(rq_data[0][1]), .req1_sel(rq_sel[0][1]),
    .resp_valid(rsp_valid[0]), .resp_ready(rsp_ready[0]), .resp_data(rsp_data[0]), .resp_id(rsp_id[0]),
    .shf_in(shf_in[0]), .shf_sel(shf_sel[0]), .shf_out(shf_out_a), .busy(busy[0]),
    .served0_cnt(cnt0_a), .served1_cnt(cnt1_a)
  );

  shifter_share_arbiter #(.FIXED_PRIO(1), .CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(rq_valid[1][0]), .req0_ready(rq_ready[1][0]), .req0_data(rq_data[1][0]), .req0_sel(rq_sel[1][0]),
    .req1_valid(rq_valid[1][1]), .req1_ready(rq_ready[1][1]), .req1_data(rq_data[1][1]), .req1_sel(rq_sel[1][1]),
    .resp_valid(rsp_valid[1]), .resp_ready(rsp_ready[1]), .resp_data(rsp_data[1]), .resp_id(rsp_id[1]),
    .shf_in(shf_in[1]), .shf_sel(shf_sel[1]), .shf_out(shf_out_b), .busy(busy[1]),
    .served0_cnt(cnt0_b), .served1_cnt(cnt1_b)
  );

  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst%0d: got %0h expected %0h at %0t", name, i, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] cnt_of(input int i, input int r);
    if (i == 0) return (r == 0) ? {30'd0, cnt0_a} : {30'd0, cnt1_a};
    return (r == 0) ? {24'd0, cnt0_b} : {24'd0, cnt1_b};
  endfunction

  // ---------------- transaction-level reference model ----------------
  // An operation is either absent, or present with an age: age 0 is the
  // shifting cycle, age 1 is the waiting-for-consumer phase.
  bit         m_has   [2];
  int         m_age   [2];
  logic [3:0] m_in    [2];
  logic [1:0] m_sel   [2];
  bit         m_opid  [2];
  bit         m_last  [2];
  logic [3:0] m_rdata [2];
  bit         m_rid   [2];
  int         m_cnt   [2][2];

  // Who may transfer this cycle, from the arbitration rules.
  function automatic logic [1:0] grant_of(input int i);
    logic [1:0] v;
    v = rq_valid[i];
    if (m_has[i]) return 2'b00;
    if (v == 2'b11) begin
      if (i == 1 || m_last[i]) return 2'b01;
      return 2'b10;
    end
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_has[i] = 0; m_age[i] = 0; m_in[i] = '0; m_sel[i] = '0; m_opid[i] = 0;
        m_last[i] = 1; m_rdata[i] = '0; m_rid[i] = 0; m_cnt[i][0] = 0; m_cnt[i][1] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        logic [1:0] g;
        int id;
        g = grant_of(i);
        if (!m_has[i]) begin
          if (g != 2'b00) begin
            id = g[1] ? 1 : 0;
            m_has[i] = 1; m_age[i] = 0;
            m_in[i] = rq_data[i][id]; m_sel[i] = rq_sel[i][id];
            m_opid[i] = (id == 1); m_last[i] = (id == 1);
          end
        end else if (m_age[i] == 0) begin
          m_age[i] = 1;
          m_rdata[i] = rotl(m_in[i], m_sel[i]);
          m_rid[i] = m_opid[i];
        end else if (rsp_ready[i]) begin
          id = m_rid[i] ? 1 : 0;
          m_cnt[i][id] = (m_cnt[i][id] + 1) & ((i == 0) ? 3 : 255);
          m_has[i] = 0;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [1:0] g;
      g = grant_of(i);
      chk("req0_ready", i, rq_ready[i][0], g[0]);
      chk("req1_ready", i, rq_ready[i][1], g[1]);
      chk("resp_valid", i, rsp_valid[i], (m_has[i] && m_age[i] == 1));
      chk("resp_data",  i, rsp_data[i], m_rdata[i]);
      chk("resp_id",    i, rsp_id[i], m_rid[i]);
      chk("shf_in",     i, shf_in[i], m_in[i]);
      chk("shf_sel",    i, shf_sel[i], m_sel[i]);
      chk("busy",       i, busy[i], m_has[i]);
      chk("served0",    i, cnt_of(i, 0), m_cnt[i][0]);
      chk("served1",    i, cnt_of(i, 1), m_cnt[i][1]);
    end
  end

  // Handshake log {id, data}, recorded the half cycle before the completing edge.
  logic [4:0] hs0[$];
  logic [4:0] hs1[$];
  always @(negedge clk) begin
    if (rst_n && rsp_valid[0] && rsp_ready[0]) hs0.push_back({rsp_id[0], rsp_data[0]});
    if (rst_n && rsp_valid[1] && rsp_ready[1]) hs1.push_back({rsp_id[1], rsp_data[1]});
  end

  // ---------------- stimulus helpers (called at posedge+2) ----------------
  task automatic issue(input int i, input int r, input logic [3:0] d, input logic [1:0] s);
    bit done;
    done = 0;
    rq_data[i][r] = d; rq_sel[i][r] = s; rq_valid[i][r] = 1'b1;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (rq_ready[i][r]) done = 1;
    end
    @(posedge clk); #2;
    rq_valid[i][r] = 1'b0;
    chk("accept_timeout", i, done, 1);
  endtask

  task automatic wait_idle(input int i);
    bit done;
    done = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (!busy[i] && !rsp_valid[i]) done = 1;
    end
    @(posedge clk); #2;
    chk("idle_timeout", i, done, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
  endtask

  initial begin
    int b;
    // reset state
    repeat (2) @(posedge clk);
    #2;
    chk("rst_resp_valid", 0, rsp_valid, 2'b00);
    chk("rst_busy", 0, busy, 2'b00);
    chk("rst_shf_in", 0, shf_in, 8'h00);
    chk("rst_cnt", 0, {cnt0_a, cnt1_a, cnt0_b, cnt1_b}, 20'h0);
    rst_n = 1'b1;

    // single request on the round-robin instance
    rsp_ready = 2'b11;
    issue(0, 0, 4'b0001, 2'b01);
    @(posedge clk); #1;
    chk("t1_resp_valid", 0, rsp_valid[0], 1);
    chk("t1_resp_data", 0, rsp_data[0], 4'b0010);
    chk("t1_resp_id", 0, rsp_id[0], 0);
    @(posedge clk); #1;
    chk("t1_served0", 0, cnt0_a, 2'd1);
    chk("t1_resp_drop", 0, rsp_valid[0], 0);
    #1;

    // simultaneous requests, round-robin, two rounds
    wait_idle(0);
    do_reset();
    b = hs0.size();
    for (int rnd = 0; rnd < 2; rnd++) begin
      fork
        issue(0, 0, 4'b1010, 2'b00);
        issue(0, 1, 4'b0011, 2'b11);
      join
    end
    wait_idle(0);
    chk("rr_count", 0, hs0.size() - b, 4);
    if (hs0.size() >= b + 4) begin
      chk("rr_first",  0, hs0[b],     {1'b0, 4'b1010});
      chk("rr_second", 0, hs0[b + 1], {1'b1, 4'b1001});
      chk("rr_third",  0, hs0[b + 2], {1'b0, 4'b1010});
      chk("rr_fourth", 0, hs0[b + 3], {1'b1, 4'b1001});
    end
    chk("rr_served", 0, {cnt0_a, cnt1_a}, {2'd2, 2'd2});

    // fixed priority: req0 re-asserts straight away and wins twice
    b = hs1.size();
    fork
      begin
        issue(1, 0, 4'b1010, 2'b00);
        issue(1, 0, 4'b0101, 2'b01);
      end
      issue(1, 1, 4'b0011, 2'b11);
    join
    wait_idle(1);
    chk("fp_count", 1, hs1.size() - b, 3);
    if (hs1.size() >= b + 3) begin
      chk("fp_first",  1, hs1[b],     {1'b0, 4'b1010});
      chk("fp_second", 1, hs1[b + 1], {1'b0, 4'b1010});
      chk("fp_third",  1, hs1[b + 2], {1'b1, 4'b1001});
    end
    chk("fp_served", 1, {cnt0_b, cnt1_b}, {8'd2, 8'd1});

    // backpressure with a competing request waiting
    rsp_ready[0] = 1'b0;
    issue(0, 1, 4'b0110, 2'b10);
    rq_data[0][0] = 4'b0001; rq_sel[0][0] = 2'b00; rq_valid[0][0] = 1'b1;
    @(posedge clk);
    repeat (5) begin
      #1;
      chk("bp_valid", 0, rsp_valid[0], 1);
      chk("bp_data", 0, rsp_data[0], 4'b1001);
      chk("bp_id", 0, rsp_id[0], 1);
      chk("bp_busy", 0, busy[0], 1);
      chk("bp_readys", 0, rq_ready[0], 2'b00);
      chk("bp_cnt", 0, {cnt0_a, cnt1_a}, {2'd2, 2'd2});
      @(posedge clk);
    end
    #2;
    rsp_ready[0] = 1'b1;
    issue(0, 0, 4'b0001, 2'b00);
    wait_idle(0);
    chk("bp_after", 0, {cnt0_a, cnt1_a}, {2'd3, 2'd3});

    // asynchronous reset during EXEC
    b = hs0.size();
    issue(0, 0, 4'b1111, 2'b01);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_resp_valid", 0, rsp_valid[0], 0);
    chk("ar_cnt", 0, {cnt0_a, cnt1_a, cnt0_b, cnt1_b}, 20'h0);
    chk("ar_shf", 0, {shf_in[0], shf_sel[0]}, 6'h0);
    chk("ar_busy", 0, busy[0], 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    issue(0, 1, 4'b1000, 2'b01);
    wait_idle(0);
    chk("ar_count", 0, hs0.size() - b, 1);
    if (hs0.size() >= b + 1) chk("ar_resp", 0, hs0[b], {1'b1, 4'b0001});
    chk("ar_served", 0, {cnt0_a, cnt1_a}, {2'd0, 2'd1});

    // counter wrap with 2-bit counters
    do_reset();
    for (int k = 0; k < 5; k++) begin
      issue(0, 1, 4'(k + 1), 2'(k));
    end
    wait_idle(0);
    chk("wrap_served1", 0, cnt1_a, 2'd1);
    chk("wrap_served0", 0, cnt0_a, 2'd0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
